add_result_responder: RTL

// - Adder-side responder for the intermediator's add interface: accepts add/add0/add1/add_row requests.
// - Returns the tagged sum after a fixed LATENCY on valid1/value1/row1, the intermediator's result-return inputs.
// - 64-bit integer stand-in for the pipelined FP adder; no backpressure, one request per cycle.
// - Also runs the flush handshake: reports when every in-flight add has drained.

---
 rtl/add_result_responder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/add_result_responder.sv
// Integer stand-in for the pipelined adder: fixed-latency tagged sums, in-flight count, flush drain tracking.
// Optional ADD_RESP_OVF_EN adds an ovf output carried alongside each sum.
//
// state   | meaning
// S_IDLE  | no drain requested; flush starts tracking
// S_DRAIN | waiting for every accepted add to return
// S_DONE  | drain complete; flush_done asserted this cycle
module add_result_responder #(
  parameter int LATENCY = 4,
  parameter int ROW_W   = 10,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             add,
  input  logic [63:0]      add0,
  input  logic [63:0]      add1,
  input  logic [ROW_W-1:0] add_row,
  input  logic             flush,
  output logic             valid1,
  output logic [63:0]      value1,
  output logic [ROW_W-1:0] row1,
  output logic [CNT_W-1:0] in_flight,
`ifdef ADD_RESP_OVF_EN
  output logic             ovf,
`endif
  output logic             flush_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [LATENCY-1:0] vld_q;
  logic [63:0]        sum_q [LATENCY];
  logic [ROW_W-1:0]   row_q [LATENCY];
  logic [63:0]        sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         state_q, state_d;

  assign sum_d = add0 + add1;

  // Data stages only load behind a valid entry so the outputs hold between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        sum_q[i] <= '0;
        row_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= add;
      if (add) begin
        sum_q[0] <= sum_d;
        row_q[0] <= add_row;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          sum_q[i] <= sum_q[i-1];
          row_q[i] <= row_q[i-1];
        end
      end
    end
  end

  assign valid1 = vld_q[LATENCY-1];
  assign value1 = sum_q[LATENCY-1];
  assign row1   = row_q[LATENCY-1];

`ifdef ADD_RESP_OVF_EN
  logic [LATENCY-1:0] ovf_q;
  logic               ovf_d;

  assign ovf_d = (add0[63] == add1[63]) && (sum_d[63] != add0[63]);

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= '0;
    end else begin
      if (add) ovf_q[0] <= ovf_d;
      for (int i = 1; i < LATENCY; i++) begin
        if (vld_q[i-1]) ovf_q[i] <= ovf_q[i-1];
      end
    end
  end

  assign ovf = valid1 & ovf_q[LATENCY-1];
`endif

  always_comb begin
    cnt_d = cnt_q;
    case ({add, valid1})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (flush) state_d = S_DRAIN;
      S_DRAIN: if (cnt_q == '0 && !add) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= S_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign in_flight  = cnt_q;
  assign flush_done = (state_q == S_DONE);

endmodule
